// File: rtl/apb_dri_cmd_initiator.sv
// Command/response stream to single APB3 transfers for the PF_DRI_C0 target.
// Define APB_DRI_WRITE_VERIFY_EN to add a readback compare after each good write.
module apb_dri_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        PCLK,
  input  logic        ARST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [28:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        rsp_mismatch,
  output logic        busy,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [28:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

`ifdef APB_DRI_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] ACCESS  = 3'd2;
  localparam logic [2:0] VSETUP  = 3'd3;
  localparam logic [2:0] VACCESS = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  logic [2:0]    state;
  logic          run_q;
  logic          write_q;
  logic [28:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    strb_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          tmo_q;
  logic          mis_q;
  logic          tmo_hit;
  logic          wphase;
  logic [31:0]   mask;
  logic          diff;

  assign wphase = (state == SETUP) || (state == ACCESS);
  assign mask = {{8{strb_q[3]}}, {8{strb_q[2]}},
                 {8{strb_q[1]}}, {8{strb_q[0]}}};
  assign diff = |((PRDATA ^ wdata_q) & mask);

  // Fires on the cycle that would be the TIMEOUT_CYCLES-th PREADY-low cycle.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && !PREADY &&
                   ((cnt + CW'(1)) == TO_LIM);

  assign cmd_ready = (state == IDLE) && run_q;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign PSEL      = wphase || (state == VSETUP) ||
                     (state == VACCESS);
  assign PENABLE   = (state == ACCESS) || (state == VACCESS);
  assign PWRITE    = write_q && wphase;
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = (write_q && wphase) ? strb_q : 4'b0000;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign rsp_timeout  = tmo_q;
  assign rsp_mismatch = mis_q;

  // cmd_ready must stay low until the first edge after reset release.
  always_ff @(posedge PCLK or posedge ARST) begin
    if (ARST) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  always_ff @(posedge PCLK or posedge ARST) begin
    if (ARST) begin
      state   <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && run_q) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            strb_q  <= cmd_strb;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            mis_q   <= 1'b0;
            cnt     <= '0;
            state   <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (PREADY) begin
            rdata_q <= write_q ? 32'h0 : PRDATA;
            err_q   <= PSLVERR;
            if (VERIFY && write_q && !PSLVERR) begin
              cnt   <= '0;
              state <= VSETUP;
            end else begin
              state <= RESP;
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            tmo_q <= 1'b1;
            state <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef APB_DRI_WRITE_VERIFY_EN
        VSETUP: state <= VACCESS;
        VACCESS: begin
          if (PREADY) begin
            rdata_q <= PRDATA;
            err_q   <= PSLVERR;
            mis_q   <= diff;
            state   <= RESP;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
            tmo_q <= 1'b1;
            state <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_dri_cmd_initiator.sv
// Directed bench for apb_dri_cmd_initiator with a small wait-state APB target.
module tb_apb_dri_cmd_initiator;

`ifdef APB_DRI_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        ARST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [28:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout, rsp_mismatch, busy;
  logic        PSEL, PENABLE, PWRITE;
  logic [28:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA = '0;
  logic        PREADY;
  logic        PSLVERR;

  int unsigned waits = 0;
  bit          stuck = 1'b0;
  bit          slverr = 1'b0;
  int unsigned wcnt = 0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  apb_dri_cmd_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .PCLK(PCLK), .ARST(ARST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  assign PREADY = PSEL && PENABLE && !stuck && (wcnt == waits);
  assign PSLVERR = slverr && PREADY;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          write;
    logic [28:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int unsigned waits;
    logic [31:0] prdata;
    bit          slverr;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_mis;
    int          lat_n;
    int          lat_v;
  } vec_t;

  vec_t vt[5];

  int lat, setups, acc;
  bit hold_ok;
  logic [31:0] snap;

  // Present a command and return just after the accepting edge.
  task automatic issue(input bit w, input logic [28:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int g;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(posedge PCLK); #1; g++;
    end
    if (!cmd_ready) begin
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $fatal(1, "no accept");
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid, counting latency, setup phases and access cycles.
  task automatic wait_rsp(input logic [3:0] xstrb, input bit w);
    lat = 0; setups = 0; acc = 0; hold_ok = 1'b1;
    if (PSEL && !PENABLE) setups++;
    while (!rsp_valid && lat < 60) begin
      @(posedge PCLK); #1; lat++;
      if (PSEL && !PENABLE) setups++;
      if (PSEL && PENABLE) acc++;
      if (PSEL && PWRITE && PSTRB !== xstrb) hold_ok = 1'b0;
      if (PSEL && PADDR !== cmd_addr) hold_ok = 1'b0;
    end
    chk("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    if (!w) chk("pwrite_rd", {31'b0, PWRITE}, 32'd0);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", {30'b0, busy, cmd_ready}, 32'b01);
  endtask

  initial begin
    vt[0] = '{0, 29'h104, 32'h0, 4'h0, 0, 32'h1234_5678, 0,
              32'h1234_5678, 0, 0, 2, 2};
    vt[1] = '{1, 29'h108, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0000_BEEF, 0,
              32'h0000_BEEF, 0, 0, 5, 10};
    vt[2] = '{1, 29'h108, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0000_BEEE, 0,
              32'h0000_BEEE, 0, 1, 5, 10};
    vt[3] = '{1, 29'h10C, 32'h0000_0001, 4'b1111, 1, 32'h5555_5555, 1,
              32'h0, 1, 0, 3, 3};
    vt[4] = '{0, 29'h110, 32'h0, 4'h0, 2, 32'hA5A5_A5A5, 1,
              32'hA5A5_A5A5, 1, 0, 4, 4};

    #12;
    chk("rst_outputs",
        {24'b0, PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, busy,
         rsp_err, rsp_timeout}, 32'h0);
    chk("rst_paddr", {3'b0, PADDR}, 32'h0);
    @(negedge PCLK); ARST = 1'b0;
    #1 chk("ready_before_edge", {31'b0, cmd_ready}, 32'd0);
    @(posedge PCLK); #1;
    chk("ready_after_edge", {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      bit rb;
      logic [3:0] xs;
      rb = VER && vt[i].write && !vt[i].slverr;
      xs = vt[i].write ? vt[i].strb : 4'b0000;
      waits = vt[i].waits; PRDATA = vt[i].prdata;
      slverr = vt[i].slverr;
      issue(vt[i].write, vt[i].addr, vt[i].wdata, vt[i].strb);
      chk($sformatf("v%0d_setup", i),
          {29'b0, PSEL, PENABLE, PWRITE},
          {29'b0, 1'b1, 1'b0, vt[i].write});
      chk($sformatf("v%0d_pstrb", i), {28'b0, PSTRB}, {28'b0, xs});
      chk($sformatf("v%0d_pwdata", i), PWDATA, vt[i].wdata);
      wait_rsp(xs, vt[i].write);
      chk($sformatf("v%0d_latency", i), lat,
          VER ? vt[i].lat_v : vt[i].lat_n);
      chk($sformatf("v%0d_setups", i), setups, rb ? 2 : 1);
      chk($sformatf("v%0d_hold", i), {31'b0, hold_ok}, 32'd1);
      chk($sformatf("v%0d_rdata", i), rsp_rdata,
          (vt[i].write && !VER) ? 32'h0 : vt[i].exp_rdata);
      chk($sformatf("v%0d_err", i),
          {30'b0, rsp_err, rsp_timeout}, {30'b0, vt[i].exp_err, 1'b0});
      chk($sformatf("v%0d_mismatch", i), {31'b0, rsp_mismatch},
          {31'b0, VER && vt[i].exp_mis});
      chk($sformatf("v%0d_resp_apb", i),
          {30'b0, PSEL, PENABLE}, 32'h0);
      consume();
    end
    slverr = 1'b0;

    // Timeout with PREADY stuck low.
    stuck = 1'b1; waits = 0;
    issue(1'b0, 29'h120, 32'h0, 4'h0);
    wait_rsp(4'h0, 1'b0);
    chk("tmo_latency", lat, 9);
    chk("tmo_access_cycles", acc, 8);
    chk("tmo_flags", {30'b0, rsp_err, rsp_timeout}, 32'b11);
    chk("tmo_apb_drop", {30'b0, PSEL, PENABLE}, 32'h0);
    consume();
    stuck = 1'b0; PRDATA = 32'hCAFE_0001;
    issue(1'b0, 29'h124, 32'h0, 4'h0);
    wait_rsp(4'h0, 1'b0);
    chk("post_tmo_latency", lat, 2);
    chk("post_tmo_rdata", rsp_rdata, 32'hCAFE_0001);
    chk("post_tmo_flags", {30'b0, rsp_err, rsp_timeout}, 32'h0);

    // Response backpressure with a pending command.
    snap = rsp_rdata;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 29'h128;
    hold_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge PCLK); #1;
      if (cmd_ready || PSEL || !rsp_valid || rsp_rdata !== snap)
        hold_ok = 1'b0;
    end
    chk("bp_hold", {31'b0, hold_ok}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk("bp_release", {29'b0, rsp_valid, cmd_ready, PSEL}, 32'b010);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    chk("bp_next_setup", {30'b0, PSEL, PENABLE}, 32'b10);
    wait_rsp(4'h0, 1'b0);
    consume();

    // Asynchronous reset during ACCESS.
    stuck = 1'b1;
    issue(1'b0, 29'h130, 32'h0, 4'h0);
    @(posedge PCLK); #1;
    @(posedge PCLK); #2;
    chk("pre_rst_access", {30'b0, PSEL, PENABLE}, 32'b11);
    ARST = 1'b1;
    #1 chk("rst_async",
           {27'b0, PSEL, PENABLE, rsp_valid, busy, cmd_ready}, 32'h0);
    @(negedge PCLK); ARST = 1'b0; stuck = 1'b0;
    #1 chk("rst_rel_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge PCLK); #1;
    chk("rst_rel_edge", {30'b0, cmd_ready, busy}, 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_dri_cmd_initiator.md
# apb_dri_cmd_initiator

APB initiator that turns a simple command/response stream from fabric logic into single APB3 transfers toward the PF_DRI_C0 APB target, so PLL/CCC DRI registers can be written and read at run time. Sits between user control logic (training/reconfiguration sequencers) and the DRI APB target. Adds a per-transfer timeout and an optional write-readback check.

## Interface
- TIMEOUT_CYCLES, 255: max ACCESS-phase cycles with PREADY low before abort; 0 disables timeout.
- PCLK  in  1  single clock for all logic.
- ARST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  29  APB address.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data (readback data on verified writes).
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- rsp_mismatch  out  1  write readback compare failed.
- busy  out  1  FSM not in IDLE.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  29; PWDATA  out  32; PSTRB  out  4  APB address/data/strobes.
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB target response.

## Operation
- States: IDLE, SETUP, ACCESS, VSETUP, VACCESS (verify only), RESP.
- IDLE: cmd_ready=1. On accept, register write/addr/wdata/strb, go SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from registers; PSTRB=0 on reads. Next cycle ACCESS.
- ACCESS: PSEL=1, PENABLE=1. On PREADY=1: capture PRDATA (reads), PSLVERR into rsp_err; go RESP (or VSETUP if verify applies). Timeout counter increments each ACCESS cycle with PREADY=0; when it equals TIMEOUT_CYCLES, drop PSEL/PENABLE, set rsp_err=1, rsp_timeout=1, go RESP.
- VSETUP/VACCESS: read to the same address, same timing/timeout rules; compare.
- RESP: rsp_valid=1, response fields stable; on rsp_ready go IDLE. cmd_ready=0 outside IDLE (no pipelining: one outstanding transfer).
- Timeout counter: width clog2(TIMEOUT_CYCLES+1), cleared on entry to SETUP/VSETUP; never wraps.
- Reset (any time, including mid-transfer): all outputs 0 asynchronously (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, cmd_ready, rsp_*, busy); FSM to IDLE; cmd_ready rises on first PCLK edge after ARST deasserts.

## Timing
- Accept at edge N; SETUP cycle N..N+1; ACCESS from N+1; with zero-wait target, PREADY sampled at N+2 and rsp_valid high from N+2 (read/unverified write latency 2 cycles accept-to-response).
- Each PREADY-low cycle adds one cycle. Timeout: rsp_valid asserts the cycle after the TIMEOUT_CYCLES-th low cycle.
- Verified write: +2 cycles minimum (VSETUP, VACCESS).
- Back-to-back: next accept earliest the cycle after rsp_valid && rsp_ready.
- PSEL/PENABLE never high in IDLE or RESP; APB signals stable across SETUP→ACCESS.

## Configuration
- APB_DRI_WRITE_VERIFY_EN defined: a write completing with PSLVERR=0 and no timeout is followed by a readback; rsp_rdata = readback; rsp_mismatch=1 if (PRDATA ^ wdata) masked by byte-expanded strb ≠ 0. Readback PSLVERR/timeout set rsp_err/rsp_timeout. Errored writes skip readback.
- Undefined: VSETUP/VACCESS absent, rsp_mismatch tied 0, rsp_rdata=0 on writes.

## Test plan
- Read, zero-wait target, PRDATA=0x1234_5678 at 0x000_0104 -> PSEL rises 1 cycle after accept, rsp_valid 2 cycles after, rsp_rdata=0x1234_5678, rsp_err=0.
- Write 0xDEAD_BEEF strb=4'b0011 to 0x000_0108, target inserts 3 wait states -> PSTRB=0011 held, rsp_valid 5 cycles after accept; with verify and readback 0x0000_BEEF, rsp_mismatch=0; readback 0x0000_BEEE -> rsp_mismatch=1.
- TIMEOUT_CYCLES=8, PREADY stuck 0 -> PSEL/PENABLE drop after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1; next command completes normally.
- PSLVERR=1 on write -> rsp_err=1, rsp_timeout=0, no readback transfer issued even with verify.
- rsp_ready held 0 for 10 cycles with cmd_valid=1 -> cmd_ready=0, no new PSEL, response fields stable.
- ARST pulsed during ACCESS -> PSEL/PENABLE/rsp_valid/busy 0 immediately; cmd_ready=1 one edge after release.
